// File: rtl/byte_encode_if.sv
// Coefficient-in / byte-out stream bundle for byte_encode.
// The master drives coefficients and accepts bytes; the slave is the packer.
interface byte_encode_if #(
    parameter int D = 4
);
    logic [D-1:0] in_coef;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   out_byte;
    logic         out_valid;
    logic         out_ready;
    logic         out_last;

    modport master (
        output in_coef, in_valid, out_ready,
        input  in_ready, out_byte, out_valid, out_last
    );

    modport slave (
        input  in_coef, in_valid, out_ready,
        output in_ready, out_byte, out_valid, out_last
    );
endinterface

// File: rtl/byte_encode.sv
// byte_encode: packs D-bit coefficients LSB-first into a little-endian byte
// stream, one polynomial of N coefficients at a time (ByteEncode_d).
module byte_encode #(
    parameter int D = 4,
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    byte_encode_if.slave bus
);
    localparam int BW  = D + 7;
    localparam int CW  = $clog2(D + 8);
    localparam int NB  = N * D / 8;
    localparam int CCW = (N > 1) ? $clog2(N) : 1;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic {FILL, EMIT} state_t;

    logic [BW-1:0]  r_buf;
    logic [CW-1:0]  r_cnt;
    logic [CCW-1:0] r_ccnt;
    logic [BCW-1:0] r_bcnt;

    logic [BW-1:0]  w_buf_nxt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [CCW-1:0] w_ccnt_nxt;
    logic [BCW-1:0] w_bcnt_nxt;
    logic [BW-1:0]  w_coef_sh;
    state_t         w_state;

    // State is implied by how many bits are buffered; no extra register.
    assign w_state   = (r_cnt >= CW'(8)) ? EMIT : FILL;
    assign w_coef_sh = {{7{1'b0}}, bus.in_coef} << r_cnt;

    assign bus.in_ready  = (w_state == FILL);
    assign bus.out_valid = (w_state == EMIT);
    assign bus.out_byte  = r_buf[7:0];
    assign bus.out_last  = (w_state == EMIT) && (r_bcnt == BCW'(NB - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf  <= '0;
            r_cnt  <= '0;
            r_ccnt <= '0;
            r_bcnt <= '0;
        end else begin
            r_buf  <= w_buf_nxt;
            r_cnt  <= w_cnt_nxt;
            r_ccnt <= w_ccnt_nxt;
            r_bcnt <= w_bcnt_nxt;
        end
    end

    always_comb begin
        w_buf_nxt  = r_buf;
        w_cnt_nxt  = r_cnt;
        w_ccnt_nxt = r_ccnt;
        w_bcnt_nxt = r_bcnt;
        if (clear) begin
            w_buf_nxt  = '0;
            w_cnt_nxt  = '0;
            w_ccnt_nxt = '0;
            w_bcnt_nxt = '0;
        end else if (w_state == FILL) begin
            if (bus.in_valid) begin
                w_buf_nxt  = r_buf | w_coef_sh;
                w_cnt_nxt  = r_cnt + CW'(D);
                w_ccnt_nxt = (r_ccnt == CCW'(N - 1)) ? '0 : r_ccnt + CCW'(1);
            end
        end else if (bus.out_ready) begin
            // N*D is a byte multiple, so the final byte leaves buf and cnt at zero.
            w_buf_nxt  = r_buf >> 8;
            w_cnt_nxt  = r_cnt - CW'(8);
            w_bcnt_nxt = (r_bcnt == BCW'(NB - 1)) ? '0 : r_bcnt + BCW'(1);
        end
    end
endmodule
